bench_slot_sequencer: RTL and testbench

- Controller that drives the 3-bit output-select code of the benchmark wrapper and so shares its single 8-bit output port among the 8 benchmark slots.
- Walks the enabled slots in manual, continuous-auto, single-sweep or single-step mode.
- Holds each slot for a programmable dwell time, then captures that slot's output byte.
- Sits between the board-level control inputs and the wrapper's output mux; hands captured bytes downstream over a valid/ready handshake.

---
 rtl/bench_slot_sequencer.sv | 140 ++++++++++++++
 tb/tb_bench_slot_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_slot_sequencer.sv
// Drives the wrapper's output-select code through the enabled slots. Each slot is held for dwell+1 cycles, and its output byte is captured in the last of them.
// Captures are registered and visible the next cycle. If cap_valid is still pending, the sequencer stalls in WAIT_CAP until cap_ready.
module bench_slot_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [2:0]         manual_sel,
  input  logic [7:0]         slot_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               pause,
  input  logic [7:0]         mux_data,
  output logic [2:0]         sel,
  output logic               slot_change,
  output logic               busy,
  output logic               sweep_done,
  output logic               cap_valid,
  output logic [7:0]         cap_data,
  output logic [2:0]         cap_slot,
  input  logic               cap_ready
);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;
  localparam logic [1:0] MODE_STEP   = 2'b11;

  typedef enum logic [1:0] {IDLE, DWELL, WAIT_CAP} state_t;

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [1:0]         run_mode, run_mode_n;
  logic [2:0]         sel_n;
  logic [2:0]         next_slot, first_slot, idx;
  logic               found, wrap, stall, cap_due, sweep_done_n;

  // Circular search starting after sel. With an empty mask it falls back to sel itself.
  always_comb begin
    next_slot = sel;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = sel + 3'(i);
      if (!found && slot_mask[idx]) begin
        next_slot = idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    first_slot = '0;
    for (int i = 7; i >= 0; i--) begin
      if (slot_mask[i]) first_slot = 3'(i);
    end
  end

  assign wrap  = (slot_mask == 8'h00) || (next_slot <= sel);
  assign stall = cap_valid && !cap_ready;
  assign busy  = (state != IDLE);

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    cnt_n        = cnt;
    run_mode_n   = run_mode;
    cap_due      = 1'b0;
    sweep_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_MANUAL) begin
          sel_n = manual_sel;
        end else if (!pause && slot_mask != 8'h00) begin
          if (mode == MODE_AUTO || (mode == MODE_SWEEP && start)) begin
            state_n    = DWELL;
            sel_n      = first_slot;
            cnt_n      = dwell;
            run_mode_n = mode;
          end else if (mode == MODE_STEP && start && !stall) begin
            cap_due = 1'b1;
            sel_n   = next_slot;
          end
        end
      end
      default: begin
        // A mode change aborts the run without a capture or sweep_done.
        if (mode != run_mode) begin
          state_n = IDLE;
        end else if (!pause) begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (stall) begin
            state_n = WAIT_CAP;
          end else begin
            cap_due = 1'b1;
            if (run_mode == MODE_SWEEP && wrap) begin
              state_n      = IDLE;
              sweep_done_n = 1'b1;
            end else begin
              state_n = DWELL;
              sel_n   = next_slot;
              cnt_n   = dwell;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      run_mode    <= MODE_MANUAL;
      slot_change <= 1'b0;
      sweep_done  <= 1'b0;
      cap_valid   <= 1'b0;
      cap_data    <= '0;
      cap_slot    <= '0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      cnt         <= cnt_n;
      run_mode    <= run_mode_n;
      slot_change <= (sel_n != sel);
      sweep_done  <= sweep_done_n;
      if (cap_due) begin
        cap_valid <= 1'b1;
        cap_data  <= mux_data;
        cap_slot  <= sel;
      end else if (cap_valid && cap_ready) begin
        cap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bench_slot_sequencer.sv
// Directed bench for bench_slot_sequencer. The wrapper mux is modelled as 8'hA0 + sel.
module tb_bench_slot_sequencer;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [2:0] manual_sel;
  logic [7:0] slot_mask;
  logic [7:0] dwell;
  logic       start;
  logic       pause;
  logic [7:0] mux_data;
  logic [2:0] sel;
  logic       slot_change;
  logic       busy;
  logic       sweep_done;
  logic       cap_valid;
  logic [7:0] cap_data;
  logic [2:0] cap_slot;
  logic       cap_ready;

  int n_checks = 0;
  int n_fail   = 0;

  int auto_sel  [9] = '{0, 0, 0, 2, 2, 2, 5, 5, 5};
  int step_sel  [3] = '{1, 3, 1};
  int step_slot [3] = '{0, 1, 3};

  bench_slot_sequencer #(.DWELL_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .manual_sel  (manual_sel),
    .slot_mask   (slot_mask),
    .dwell       (dwell),
    .start       (start),
    .pause       (pause),
    .mux_data    (mux_data),
    .sel         (sel),
    .slot_change (slot_change),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .cap_valid   (cap_valid),
    .cap_data    (cap_data),
    .cap_slot    (cap_slot),
    .cap_ready   (cap_ready)
  );

  always_comb mux_data = 8'hA0 + {5'd0, sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; manual_sel = 3'd0; slot_mask = 8'h00;
    dwell = 8'd0; start = 1'b0; pause = 1'b0; cap_ready = 1'b0;
    tick();
    tick();
    check("rst_sel", sel, 0);
    check("rst_cap_valid", cap_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_slot_change", slot_change, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_cap_data", cap_data, 0);
    check("rst_cap_slot", cap_slot, 0);

    // Auto mode over slots 0, 2 and 5 with a three-cycle hold per slot.
    reset = 1'b0; mode = 2'b01; slot_mask = 8'h25; dwell = 8'd2; cap_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("auto_sel", sel, auto_sel[i]);
      check("auto_busy", busy, 1);
      if (i == 3) begin
        check("auto_cap0_valid", cap_valid, 1);
        check("auto_cap0_slot", cap_slot, 0);
        check("auto_cap0_data", cap_data, 8'hA0);
        check("auto_chg_2", slot_change, 1);
      end
      if (i == 4) begin
        check("auto_chg_hold", slot_change, 0);
        check("auto_cap_clear", cap_valid, 0);
      end
      if (i == 6) begin
        check("auto_cap2_slot", cap_slot, 2);
        check("auto_cap2_data", cap_data, 8'hA2);
      end
    end
    tick();
    check("auto_cap5_slot", cap_slot, 5);
    check("auto_cap5_data", cap_data, 8'hA5);
    check("auto_wrap_sel", sel, 0);
    check("auto_wrap_chg", slot_change, 1);

    // A mode change aborts the run. A single sweep then visits slot 0 and slot 7.
    mode = 2'b10; slot_mask = 8'h81; dwell = 8'd1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_sel", sel, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sweep_start_busy", busy, 1);
    check("sweep_start_sel", sel, 0);
    tick();
    check("sweep_sel_b", sel, 0);
    tick();
    check("sweep_sel_c", sel, 7);
    check("sweep_cap0_slot", cap_slot, 0);
    check("sweep_cap0_valid", cap_valid, 1);
    tick();
    check("sweep_sel_d", sel, 7);
    check("sweep_done_early", sweep_done, 0);
    tick();
    check("sweep_cap7_slot", cap_slot, 7);
    check("sweep_cap7_data", cap_data, 8'hA7);
    check("sweep_done_pulse", sweep_done, 1);
    check("sweep_end_busy", busy, 0);
    tick();
    check("sweep_done_clear", sweep_done, 0);
    check("sweep_end_sel", sel, 7);
    check("sweep_idle_busy", busy, 0);

    // dwell 0 with a full mask: capture every cycle until backpressure stalls the walk.
    mode = 2'b01; slot_mask = 8'hFF; dwell = 8'd0; cap_ready = 1'b1;
    tick();
    check("d0_sel0", sel, 0);
    tick();
    check("d0_cap0_slot", cap_slot, 0);
    check("d0_sel1", sel, 1);
    cap_ready = 1'b0;
    tick();
    tick();
    check("stall_sel", sel, 1);
    check("stall_busy", busy, 1);
    check("stall_cap_slot", cap_slot, 0);
    check("stall_cap_valid", cap_valid, 1);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    check("release_cap_slot", cap_slot, 1);
    check("release_cap_data", cap_data, 8'hA1);
    check("release_sel", sel, 2);

    // Abort to manual mode to park sel at 0, then step through mask 0x0A.
    mode = 2'b00; manual_sel = 3'd0; cap_ready = 1'b1;
    tick();
    check("man_abort_busy", busy, 0);
    tick();
    check("man_sel0", sel, 0);
    mode = 2'b11; slot_mask = 8'h0A;
    tick();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("step_sel", sel, step_sel[i]);
      check("step_cap_slot", cap_slot, step_slot[i]);
      check("step_cap_valid", cap_valid, 1);
      check("step_busy", busy, 0);
      tick();
      check("step_busy_after", busy, 0);
    end

    // Pause freezes the counter, so the capture still needs the remaining two cycles.
    mode = 2'b01; slot_mask = 8'h08; dwell = 8'd3; cap_ready = 1'b0;
    tick();
    check("pause_entry_sel", sel, 3);
    check("pause_entry_chg", slot_change, 1);
    tick();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_sel", sel, 3);
      check("pause_busy", busy, 1);
      check("pause_no_cap", cap_valid, 0);
    end
    pause = 1'b0;
    tick();
    tick();
    check("pause_cnt_frozen", cap_valid, 0);
    tick();
    check("pause_cap_valid", cap_valid, 1);
    check("pause_cap_slot", cap_slot, 3);
    check("self_next_no_chg", slot_change, 0);
    check("self_next_sel", sel, 3);
    mode = 2'b00; manual_sel = 3'd6;
    tick();
    tick();
    check("manual_sel6", sel, 6);
    check("pending_held", cap_valid, 1);
    check("pending_slot", cap_slot, 3);
    check("manual_busy", busy, 0);
    cap_ready = 1'b1;
    tick();
    check("pending_clear", cap_valid, 0);

    // An empty mask never starts a run in any sequencing mode.
    slot_mask = 8'h00;
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("mask0_busy", busy, 0);
      check("mask0_no_cap", cap_valid, 0);
      check("mask0_sel", sel, 6);
    end

    // Reset in the middle of a dwell clears every output.
    mode = 2'b01; slot_mask = 8'h30; dwell = 8'd0; cap_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_sel", sel, 5);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_cap_data", cap_data, 8'hA4);
    reset = 1'b1;
    tick();
    check("mid_rst_sel", sel, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cap_valid", cap_valid, 0);
    check("mid_rst_cap_data", cap_data, 0);
    check("mid_rst_cap_slot", cap_slot, 0);
    check("mid_rst_slot_change", slot_change, 0);
    check("mid_rst_sweep_done", sweep_done, 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
